// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters.
// Latency: 1 cycle from req_valid (idle arbiter, tx_busy low) to tx_go; at least 1 idle cycle between bytes.
// Backpressure: requesters hold valid/data until a one-cycle req_ready; no launch while tx_busy is high.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_go,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 grant_active,
    output logic                 timeout_err
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int WDW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]     state_q,        state_d;
    logic [IDW-1:0] grant_id_q,     grant_id_d;
    logic [IDW-1:0] rr_start_q,     rr_start_d;
    logic           owner_valid_q,  owner_valid_d;
    logic [BCW-1:0] burst_cnt_q,    burst_cnt_d;
    logic [WDW-1:0] wd_cnt_q,       wd_cnt_d;
    logic [7:0]     tx_data_q,      tx_data_d;
    logic           grant_active_q, grant_active_d;

    logic           keep_owner;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] win_idx;
    logic           wd_expired;

    // Winner selection: continue the current burst if allowed, otherwise the
    // first valid requester in rotation order starting at rr_start_q.
    always_comb begin
        int idx;
        idx        = 0;
        scan_idx   = '0;
        keep_owner = owner_valid_q && req_valid[grant_id_q] &&
                     (burst_cnt_q < BCW'(MAX_BURST));
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_start_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                scan_idx = IDW'(idx);
            end
        end
        win_idx = keep_owner ? grant_id_q : scan_idx;
    end

    assign wd_expired = (wd_cnt_q == WDW'(BUSY_TIMEOUT - 1));

    // Next-state logic for the launch / busy-rise / busy-fall sequence.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        rr_start_d     = rr_start_q;
        owner_valid_d  = owner_valid_q;
        burst_cnt_d    = burst_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        tx_data_d      = tx_data_q;
        grant_active_d = grant_active_q;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && !tx_busy) begin
                    tx_data_d      = req_data[8*int'(win_idx) +: 8];
                    grant_id_d     = win_idx;
                    rr_start_d     = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                    owner_valid_d  = 1'b1;
                    burst_cnt_d    = keep_owner ? burst_cnt_q + 1'b1 : BCW'(1);
                    grant_active_d = 1'b1;
                    state_d        = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wd_expired) begin
                    // Byte is dropped; rotation resumes after the failed owner.
                    grant_active_d = 1'b0;
                    owner_valid_d  = 1'b0;
                    burst_cnt_d    = '0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                if (!tx_busy) begin
                    grant_active_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= '0;
            rr_start_q     <= '0;
            owner_valid_q  <= 1'b0;
            burst_cnt_q    <= '0;
            wd_cnt_q       <= '0;
            tx_data_q      <= '0;
            grant_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            rr_start_q     <= rr_start_d;
            owner_valid_q  <= owner_valid_d;
            burst_cnt_q    <= burst_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            tx_data_q      <= tx_data_d;
            grant_active_q <= grant_active_d;
        end
    end

    // Launch strobes are decoded from the LAUNCH state so reset clears them at once.
    assign tx_go        = (state_q == ST_LAUNCH);
    assign req_ready    = tx_go ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign timeout_err  = (state_q == ST_WAIT_BUSY) && !tx_busy && wd_expired;
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: burst rotation, watchdog, async reset.
// Two instances: MAX_BURST=4 for most steps, MAX_BURST=1 for strict alternation.
// Transmitter model raises busy the cycle after tx_go and holds it 10 cycles.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // Instance A (MAX_BURST=4)
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            tx_go;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic            timeout_err;

    // Instance B (MAX_BURST=1)
    logic [NR-1:0]   req_valid2 = '0;
    logic [8*NR-1:0] req_data2  = '0;
    logic [NR-1:0]   req_ready2;
    logic            tx_go2;
    logic [7:0]      tx_data2;
    logic            tx_busy2;
    logic [1:0]      grant_id2;
    logic            grant_active2;
    logic            timeout_err2;

    // Requester models: valid while accepted count is below target.
    int acc_cnt [NR] = '{default: 0};
    int target  [NR] = '{default: 0};
    int base    [NR] = '{default: 0};

    int  busy_cnt   = 0;
    int  busy_cnt2  = 0;
    bit  never_busy = 1'b0;
    bit  force_busy = 1'b0;
    bit  stray2     = 1'b0;
    int  go_cnt     = 0;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .BUSY_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_go(tx_go), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_active(grant_active), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(1), .BUSY_TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .tx_go(tx_go2), .tx_data(tx_data2), .tx_busy(tx_busy2),
        .grant_id(grant_id2), .grant_active(grant_active2), .timeout_err(timeout_err2)
    );

    initial forever #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (acc_cnt[i] < target[i]);
            req_data[8*i +: 8] = 8'(base[i] + acc_cnt[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
        end
        if (tx_go) go_cnt <= go_cnt + 1;
        if (req_ready2[0] || req_ready2[2]) stray2 <= 1'b1;
    end

    // Transmitter models
    always @(posedge clk) begin
        if (tx_go && !never_busy) busy_cnt <= 10;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
        if (tx_go2)               busy_cnt2 <= 10;
        else if (busy_cnt2 > 0)   busy_cnt2 <= busy_cnt2 - 1;
    end
    assign tx_busy  = (busy_cnt != 0) || force_busy;
    assign tx_busy2 = (busy_cnt2 != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the next tx_go, then check owner, data and ready.
    task automatic wait_launch(input int id, input int dat, input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            lat = n + 1;
            if (tx_go) seen = 1'b1;
        end
        chk({tag, "_go"},    32'(seen), 32'd1);
        chk({tag, "_id"},    32'(grant_id), 32'(id));
        chk({tag, "_data"},  32'(tx_data), 32'(dat));
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!grant_active && !tx_busy) done = 1'b1;
        end
        chk({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int early;
        int e2_id  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int e2_dat [9] = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23, 'h14};
        int e3_id  [4] = '{1, 3, 1, 3};
        bit seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_go",        32'(tx_go), 32'd0);
        chk("rst_req_ready",    32'(req_ready), 32'd0);
        chk("rst_tx_data",      32'(tx_data), 32'd0);
        chk("rst_grant_id",     32'(grant_id), 32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_timeout_err",  32'(timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xAB from requester 0
        base[0]   = 'hAB - acc_cnt[0];
        target[0] = acc_cnt[0] + 1;
        early     = go_cnt;
        wait_launch(0, 'hAB, "t1", lat);
        chk("t1_latency", 32'(lat), 32'd1);
        repeat (2) @(negedge clk);
        chk("t1_busy_active", 32'(grant_active && tx_busy), 32'd1);
        for (int n = 0; n < 50 && tx_busy; n++) @(negedge clk);
        chk("t1_active_at_fall", 32'(grant_active), 32'd1);
        @(negedge clk);
        chk("t1_active_cleared", 32'(grant_active), 32'd0);
        chk("t1_go_count", 32'(go_cnt - early), 32'd1);

        // Two requesters, bursts of 4
        do_reset();
        base[0] = 'h10 - acc_cnt[0]; target[0] = acc_cnt[0] + 5;
        base[1] = 'h20 - acc_cnt[1]; target[1] = acc_cnt[1] + 4;
        for (int k = 0; k < 9; k++) begin
            wait_launch(e2_id[k], e2_dat[k], $sformatf("t2_%0d", k), lat);
        end
        wait_idle("t2");

        // Watchdog: transmitter never acknowledges
        do_reset();
        never_busy = 1'b1;
        base[0] = 'h40 - acc_cnt[0]; target[0] = acc_cnt[0] + 1;
        base[1] = 'h41 - acc_cnt[1]; target[1] = acc_cnt[1] + 1;
        wait_launch(0, 'h40, "t4_first", lat);
        early = 0;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            if (timeout_err) early++;
        end
        chk("t4_no_early_timeout", 32'(early), 32'd0);
        @(negedge clk);
        chk("t4_timeout_at_16", 32'(timeout_err), 32'd1);
        never_busy = 1'b0;
        @(negedge clk);
        chk("t4_timeout_one_cycle", 32'(timeout_err), 32'd0);
        chk("t4_active_cleared", 32'(grant_active), 32'd0);
        wait_launch(1, 'h41, "t4_next", lat);
        chk("t4_next_latency", 32'(lat), 32'd1);
        wait_idle("t4");

        // Async reset while in WAIT_DONE
        do_reset();
        base[0] = 'h55 - acc_cnt[0]; target[0] = acc_cnt[0] + 2;
        wait_launch(0, 'h55, "t5_first", lat);
        repeat (3) @(negedge clk);
        chk("t5_in_wait_done", 32'(grant_active && tx_busy), 32'd1);
        force_busy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", 32'({tx_go, req_ready, tx_data, grant_id, grant_active, timeout_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        early = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_go) early++;
        end
        chk("t5_no_go_while_busy", 32'(early), 32'd0);
        force_busy = 1'b0;
        wait_launch(0, 'h56, "t5_after", lat);
        chk("t5_after_latency", 32'(lat), 32'd1);
        wait_idle("t5");

        // Owner drops valid mid-burst; then a lone requester re-grants itself
        do_reset();
        base[2] = 'h60 - acc_cnt[2]; target[2] = acc_cnt[2] + 2;
        wait_launch(2, 'h60, "t6_a", lat);
        base[0] = 'h70 - acc_cnt[0]; target[0] = acc_cnt[0] + 6;
        wait_launch(2, 'h61, "t6_b", lat);
        chk("t6_b_burst", 32'(u_dut.burst_cnt_q), 32'd2);
        wait_launch(0, 'h70, "t6_c", lat);
        chk("t6_c_burst", 32'(u_dut.burst_cnt_q), 32'd1);
        for (int k = 1; k < 5; k++) begin
            wait_launch(0, 'h70 + k, $sformatf("t6_d%0d", k), lat);
        end
        chk("t6_wrap_burst", 32'(u_dut.burst_cnt_q), 32'd1);
        wait_launch(0, 'h75, "t6_e", lat);
        wait_idle("t6");

        // MAX_BURST=1: requesters 1 and 3 alternate
        req_data2  = {8'h33, 8'h22, 8'h11, 8'h00};
        req_valid2 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int n = 0; n < 200 && !seen; n++) begin
                @(negedge clk);
                if (tx_go2) seen = 1'b1;
            end
            chk($sformatf("t3_%0d_go", k),    32'(seen), 32'd1);
            chk($sformatf("t3_%0d_id", k),    32'(grant_id2), 32'(e3_id[k]));
            chk($sformatf("t3_%0d_data", k),  32'(tx_data2), (e3_id[k] == 1) ? 32'h11 : 32'h33);
            chk($sformatf("t3_%0d_ready", k), 32'(req_ready2), 32'(1 << e3_id[k]));
        end
        req_valid2 = 4'b0000;
        repeat (2) @(negedge clk);
        chk("t3_no_stray_ready", 32'(stray2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
